// File: rtl/file_mac_unit.sv
// Scalar multiply-accumulate engine with a sticky overflow flag,
// a zero flag and a delayed view of the accumulator low byte.
module file_mac_unit #(
    parameter int WIDTH     = 8,
    parameter int par       = 3,
    parameter int MUL_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             a,
    input  logic             b,
    input  logic [4:0]       x,
    output logic [WIDTH-1:0] data_out,
    output logic             out,
    output logic             d
);

    localparam int PW = WIDTH + 5;

    logic [PW-1:0]        prod;
    logic [MUL_WIDTH:0]   sum;
    logic [MUL_WIDTH-1:0] acc;
    logic [MUL_WIDTH-1:0] acc_next;
    logic                 out_next;
    logic [WIDTH-1:0]     stage [par];

    assign prod = PW'(data_in) * PW'(x);
    assign sum  = {1'b0, acc} + (MUL_WIDTH + 1)'(prod);

    // Select the next accumulator and overflow value from the strobes
    always_comb begin
        acc_next = acc;
        out_next = out;
        case ({a, b})
            2'b10: begin
                acc_next = sum[MUL_WIDTH-1:0];
                out_next = out | sum[MUL_WIDTH];
            end
            2'b01: begin
                acc_next = '0;
                out_next = 1'b0;
            end
            2'b11: begin
                acc_next = MUL_WIDTH'(prod);
                out_next = 1'b0;
            end
            default: begin
                acc_next = acc;
                out_next = out;
            end
        endcase
    end

    // Accumulator and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            out <= 1'b0;
            d   <= 1'b1;
        end else begin
            acc <= acc_next;
            out <= out_next;
            d   <= (acc_next == '0);
        end
    end

    // Low-byte delay line, shifted every cycle and flushed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < par; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= acc_next[WIDTH-1:0];
            for (int k = 1; k < par; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign data_out = stage[par-1];

endmodule

// File: tb/tb_file_mac_unit.sv
// Self-checking bench for file_mac_unit: scoreboard on data_out plus
// directed checks of the flag and latency behaviour.
module tb_file_mac_unit;

    localparam int WIDTH = 8;
    localparam int PAR   = 3;
    localparam int MW    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [4:0]       x = '0;
    logic [WIDTH-1:0] data_out;
    logic             out;
    logic             d;

    int checks   = 0;
    int failures = 0;

    logic [MW-1:0]    m_acc = '0;
    logic             m_out = 1'b0;
    logic [WIDTH-1:0] sb [$];

    always #5 clk = ~clk;

    file_mac_unit #(
        .WIDTH(WIDTH),
        .par(PAR),
        .MUL_WIDTH(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .a(a),
        .b(b),
        .x(x),
        .data_out(data_out),
        .out(out),
        .d(d)
    );

    // Drive one edge, advance the reference model, and compare the
    // scoreboard entry that leaves the delay line on this edge.
    task automatic cycle(input logic r, input logic ai, input logic bi,
                         input logic [WIDTH-1:0] di, input logic [4:0] xi);
        logic [MW:0]      s;
        logic [12:0]      p;
        logic [WIDTH-1:0] e;
        rst     = r;
        a       = ai;
        b       = bi;
        data_in = di;
        x       = xi;
        @(posedge clk);
        #1;
        p = 13'(di) * 13'(xi);
        if (r) begin
            m_acc = '0;
            m_out = 1'b0;
            sb.delete();
            for (int i = 0; i < PAR - 1; i++) sb.push_back('0);
            e = '0;
        end else begin
            case ({ai, bi})
                2'b10: begin
                    s     = {1'b0, m_acc} + 17'(p);
                    m_acc = s[MW-1:0];
                    m_out = m_out | s[MW];
                end
                2'b01: begin
                    m_acc = '0;
                    m_out = 1'b0;
                end
                2'b11: begin
                    m_acc = MW'(p);
                    m_out = 1'b0;
                end
                default: ;
            endcase
            sb.push_back(m_acc[WIDTH-1:0]);
            e = sb.pop_front();
        end
        checks++;
        if (data_out !== e) begin
            failures++;
            $display("FAIL sb_data_out got=%0d exp=%0d t=%0t", data_out, e, $time);
        end
        checks++;
        if (out !== m_out) begin
            failures++;
            $display("FAIL sb_out got=%b exp=%b t=%0t", out, m_out, $time);
        end
        checks++;
        if (d !== (m_acc == '0)) begin
            failures++;
            $display("FAIL sb_d got=%b exp=%b t=%0t", d, (m_acc == '0), $time);
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 8'd99, 5'd9);
        checks++;
        if ({data_out, out, d} !== {8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset got=%0h/%b/%b exp=0/0/1", data_out, out, d);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'd55, 5'd7);
        checks++;
        if ({data_out, out, d} !== {8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_hold got=%0h/%b/%b exp=0/0/1", data_out, out, d);
        end
    endtask

    task automatic test_accumulate();
        cycle(1'b0, 1'b1, 1'b0, 8'd10, 5'd3);
        checks++;
        if (d !== 1'b0) begin
            failures++;
            $display("FAIL acc_d got=%b exp=0", d);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'd10, 5'd3);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        checks++;
        if (data_out !== 8'd30) begin
            failures++;
            $display("FAIL acc_first got=%0d exp=30", data_out);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        checks++;
        if (data_out !== 8'd60) begin
            failures++;
            $display("FAIL acc_second got=%0d exp=60", data_out);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b0, 1'b0, 1'b1, 8'd0, 5'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'd255, 5'd31);
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL ovf_early got=%b exp=0", out);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'd255, 5'd31);
        checks++;
        if (out !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=1", out);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        checks++;
        if ({data_out, out, d} !== {8'hE9, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ovf_wrap got=%0h/%b/%b exp=e9/1/0", data_out, out, d);
        end
    endtask

    task automatic test_clear();
        cycle(1'b0, 1'b0, 1'b1, 8'd200, 5'd20);
        checks++;
        if ({out, d} !== 2'b01) begin
            failures++;
            $display("FAIL clear_flags got=%b%b exp=01", out, d);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        checks++;
        if (data_out !== 8'd0) begin
            failures++;
            $display("FAIL clear_data got=%0d exp=0", data_out);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 8'd255, 5'd31);
        cycle(1'b0, 1'b1, 1'b1, 8'd7, 5'd5);
        checks++;
        if ({out, d} !== 2'b00) begin
            failures++;
            $display("FAIL load_flags got=%b%b exp=00", out, d);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd123, 5'd0);
        checks++;
        if (data_out !== 8'd35) begin
            failures++;
            $display("FAIL load_data got=%0d exp=35", data_out);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        checks++;
        if ({data_out, d} !== {8'd35, 1'b0}) begin
            failures++;
            $display("FAIL x_zero got=%0d/%b exp=35/0", data_out, d);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b1, 1'b0, 8'd10, 5'd3);
        cycle(1'b0, 1'b1, 1'b0, 8'd11, 5'd4);
        cycle(1'b1, 1'b1, 1'b0, 8'd12, 5'd5);
        checks++;
        if ({data_out, out, d} !== {8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid got=%0h/%b/%b exp=0/0/1", data_out, out, d);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        checks++;
        if (data_out !== 8'd0) begin
            failures++;
            $display("FAIL rst_flush got=%0d exp=0", data_out);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
                  8'($urandom), 5'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_overflow();
        test_clear();
        test_load();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
